alarm_mode_ctrl: RTL

Mode sequencer for the MM:SS alarm clock. It owns the user-facing state machine (run, set time, set alarm, ringing, snooze). It steers the debounced increment button to either the time counter or the alarm register, and detects the alarm match once per second. It also selects and flashes the four BCD digits handed to the seven-segment display driver.

---
 rtl/alarm_mode_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/alarm_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alarm_mode_ctrl
// Purpose  : MM:SS alarm clock mode sequencer: button steering, alarm match,
//            ring/snooze timing and display digit selection.
// Revision : 1.0 - initial release
// ============================================================================
module alarm_mode_ctrl #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz_i,
  input  logic       mode_p_i,
  input  logic       inc_p_i,
  input  logic       ack_p_i,
  input  logic [3:0] t0_i,
  input  logic [3:0] t1_i,
  input  logic [3:0] t2_i,
  input  logic [3:0] t3_i,
  input  logic [3:0] a0_i,
  input  logic [3:0] a1_i,
  input  logic [3:0] a2_i,
  input  logic [3:0] a3_i,
  output logic       inc_time_o,
  output logic       inc_alarm_o,
  output logic       buzzer_o,
  output logic       armed_o,
  output logic [2:0] state_o,
  output logic [3:0] d0_o,
  output logic [3:0] d1_o,
  output logic [3:0] d2_o,
  output logic [3:0] d3_o
);

  localparam logic [2:0] c_RUN       = 3'd0;
  localparam logic [2:0] c_SET_TIME  = 3'd1;
  localparam logic [2:0] c_SET_ALARM = 3'd2;
  localparam logic [2:0] c_RINGING   = 3'd3;
  localparam logic [2:0] c_SNOOZE    = 3'd4;

  localparam logic [5:0]  c_RING_LIMIT = RING_SECS[5:0];
  localparam logic [8:0]  c_SNOOZE_LD  = SNOOZE_SECS[8:0];
  localparam logic [15:0] c_BLANK      = {4{4'b1010}};

  logic [2:0]  state_q, state_d;
  logic        armed_q, armed_d;
  logic [5:0]  ring_cnt_q, ring_cnt_d;
  logic [8:0]  snooze_cnt_q, snooze_cnt_d;
  logic        flash_q, flash_d;
  logic        inc_time_q, inc_time_d;
  logic        inc_alarm_q, inc_alarm_d;
  logic        buzzer_q, buzzer_d;
  logic [15:0] digits_q, digits_d;

  logic [15:0] w_time;
  logic [15:0] w_alarm;
  logic        w_match;
  logic [5:0]  w_ring_next;

  assign w_time      = {t3_i, t2_i, t1_i, t0_i};
  assign w_alarm     = {a3_i, a2_i, a1_i, a0_i};
  assign w_match     = (w_time == w_alarm);
  assign w_ring_next = (ring_cnt_q == 6'h3F) ? ring_cnt_q : ring_cnt_q + 6'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= c_RUN;
      armed_q      <= 1'b0;
      ring_cnt_q   <= 6'd0;
      snooze_cnt_q <= 9'd0;
      flash_q      <= 1'b0;
      inc_time_q   <= 1'b0;
      inc_alarm_q  <= 1'b0;
      buzzer_q     <= 1'b0;
      digits_q     <= w_time;
    end else begin
      state_q      <= state_d;
      armed_q      <= armed_d;
      ring_cnt_q   <= ring_cnt_d;
      snooze_cnt_q <= snooze_cnt_d;
      flash_q      <= flash_d;
      inc_time_q   <= inc_time_d;
      inc_alarm_q  <= inc_alarm_d;
      buzzer_q     <= buzzer_d;
      digits_q     <= digits_d;
    end
  end

  // A button only pre-empts lower-priority events when it has an effect in
  // the current state; an ignored press leaves ticks free to act.
  always_comb begin
    state_d      = state_q;
    armed_d      = armed_q;
    ring_cnt_d   = ring_cnt_q;
    snooze_cnt_d = snooze_cnt_q;
    flash_d      = flash_q;
    case (state_q)
      c_RUN: begin
        if (ack_p_i) begin
          armed_d = ~armed_q;
        end else if (mode_p_i) begin
          state_d = c_SET_TIME;
        end else if (tick_1hz_i && armed_q && w_match) begin
          state_d    = c_RINGING;
          ring_cnt_d = 6'd0;
          flash_d    = 1'b0;
        end
      end
      c_SET_TIME: begin
        if (mode_p_i) state_d = c_SET_ALARM;
      end
      c_SET_ALARM: begin
        if (mode_p_i) state_d = c_RUN;
      end
      c_RINGING: begin
        if (ack_p_i) begin
          state_d = c_RUN;
        end else if (inc_p_i) begin
          state_d      = c_SNOOZE;
          snooze_cnt_d = c_SNOOZE_LD;
        end else if (tick_1hz_i) begin
          ring_cnt_d = w_ring_next;
          flash_d    = ~flash_q;
          if (w_ring_next == c_RING_LIMIT) state_d = c_RUN;
        end
      end
      c_SNOOZE: begin
        if (ack_p_i) begin
          state_d = c_RUN;
        end else if (tick_1hz_i) begin
          if (snooze_cnt_q <= 9'd1) begin
            snooze_cnt_d = 9'd0;
            state_d      = c_RINGING;
            ring_cnt_d   = 6'd0;
            flash_d      = 1'b0;
          end else begin
            snooze_cnt_d = snooze_cnt_q - 9'd1;
          end
        end
      end
      default: state_d = c_RUN;
    endcase
  end

  // Outputs are computed from the next state so they land on the same edge.
  always_comb begin
    inc_time_d  = (state_q == c_SET_TIME)  && inc_p_i && !mode_p_i;
    inc_alarm_d = (state_q == c_SET_ALARM) && inc_p_i && !mode_p_i;
    buzzer_d    = (state_d == c_RINGING);
    if (state_d == c_SET_ALARM) begin
      digits_d = w_alarm;
    end else if ((state_d == c_RINGING) && flash_d) begin
      digits_d = c_BLANK;
    end else begin
      digits_d = w_time;
    end
  end

  assign inc_time_o  = inc_time_q;
  assign inc_alarm_o = inc_alarm_q;
  assign buzzer_o    = buzzer_q;
  assign armed_o     = armed_q;
  assign state_o     = state_q;
  assign d0_o        = digits_q[3:0];
  assign d1_o        = digits_q[7:4];
  assign d2_o        = digits_q[11:8];
  assign d3_o        = digits_q[15:12];

endmodule
`default_nettype wire
